// File: rtl/video_pkg.sv
// Shared stream types and width helpers for the video pipeline (crop, binning).
package video_pkg;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vid_ctl_t;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_FRAME
  } crop_state_t;

  localparam logic HS_BLANK = 1'b1;

  // Counter width able to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/video_crop.sv
// Crops a frame-start-captured ROI out of a di/de/hs/vs raster stream.
// All outputs registered, 1 clk latency; no backpressure (stream is free-running).
module video_crop
  import video_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 8,
  parameter int LINE_SIZE_MAX   = 4096,
  parameter int FRAME_LINES_MAX = 4096,
  parameter int EVEN_ALIGN      = 1,
  localparam int XW = cnt_width(LINE_SIZE_MAX),
  localparam int YW = cnt_width(FRAME_LINES_MAX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bypass,
  input  logic [XW-1:0]          roi_x,
  input  logic [YW-1:0]          roi_y,
  input  logic [XW-1:0]          roi_w,
  input  logic [YW-1:0]          roi_h,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   roi_err_o
);

  localparam logic [XW-1:0] XMASK = ~XW'(EVEN_ALIGN != 0);
  localparam logic [YW-1:0] YMASK = ~YW'(EVEN_ALIGN != 0);
  localparam vid_ctl_t CTL_RST = '{de: 1'b0, hs: HS_BLANK, vs: 1'b0};

  crop_state_t            state_q, state_d;
  logic [XW-1:0]          x_q, x_d, max_x_q, max_x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   line_de_q, line_de_d;
  logic                   hs_prev_q, hs_prev_d;
  logic                   bypass_q, bypass_d;
  logic [XW-1:0]          rx_q, rx_d, rw_q, rw_d;
  logic [YW-1:0]          ry_q, ry_d, rh_q, rh_d;
  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  vid_ctl_t               ctl_q, ctl_d;
  logic                   err_q, err_d;

  logic          start, active, frame_end, line_end, byp, kx, ky;
  logic [XW-1:0] rx, rw, x_cur, max_cur, width_seen;
  logic [YW-1:0] ry, rh, y_cur;
  logic          line_de_cur, hs_prev_cur;
  logic [YW:0]   lines_seen;

  always_comb begin
    start  = (state_q == ST_IDLE) && vs_i;
    active = start || (state_q == ST_FRAME);
    frame_end = (state_q == ST_FRAME) && !vs_i;

    // The frame-start cycle already uses the freshly captured ROI and cleared counters.
    rx  = start ? (roi_x & XMASK) : rx_q;
    rw  = start ? (roi_w & XMASK) : rw_q;
    ry  = start ? (roi_y & YMASK) : ry_q;
    rh  = start ? (roi_h & YMASK) : rh_q;
    byp = start ? bypass : bypass_q;

    x_cur       = start ? '0 : x_q;
    y_cur       = start ? '0 : y_q;
    max_cur     = start ? '0 : max_x_q;
    line_de_cur = start ? 1'b0 : line_de_q;
    hs_prev_cur = start ? HS_BLANK : hs_prev_q;
    line_end    = hs_i && !hs_prev_cur;

    kx = (x_cur >= rx) && ((x_cur - rx) < rw);
    ky = (y_cur >= ry) && ((y_cur - ry) < rh);

    width_seen = (x_cur > max_cur) ? x_cur : max_cur;
    lines_seen = {1'b0, y_cur} + {{YW{1'b0}}, line_de_cur};

    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    max_x_d   = max_x_q;
    line_de_d = line_de_q;
    hs_prev_d = hs_i;
    bypass_d  = bypass_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    ry_d      = ry_q;
    rh_d      = rh_q;
    do_d      = do_q;
    ctl_d     = CTL_RST;
    err_d     = 1'b0;

    case (state_q)
      ST_SYNC: begin
        do_d = '0;
        if (!vs_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (vs_i) begin
          state_d  = ST_FRAME;
          rx_d     = rx;
          rw_d     = rw;
          ry_d     = ry;
          rh_d     = rh;
          bypass_d = byp;
        end
      end
      ST_FRAME: begin
        if (!vs_i) state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase

    if (active) begin
      ctl_d.vs = vs_i;
      if (byp) begin
        do_d     = di_i;
        ctl_d.de = de_i;
        ctl_d.hs = hs_i;
      end else begin
        ctl_d.de = de_i && kx && ky;
        ctl_d.hs = ky ? hs_i : HS_BLANK;
        if (ctl_d.de) do_d = di_i;
      end

      x_d       = x_cur;
      y_d       = y_cur;
      max_x_d   = max_cur;
      line_de_d = line_de_cur || de_i;
      if (line_end) begin
        x_d       = '0;
        line_de_d = 1'b0;
        if (x_cur > max_cur) max_x_d = x_cur;
        // A line closing together with the frame is not counted.
        if (line_de_cur && (y_cur != '1) && !frame_end) y_d = y_cur + YW'(1);
      end else if (de_i && (x_cur != '1)) begin
        x_d = x_cur + XW'(1);
      end

      err_d = frame_end && !byp &&
              ((({1'b0, rx} + {1'b0, rw}) > {1'b0, width_seen}) ||
               (({1'b0, ry} + {1'b0, rh}) > lines_seen));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SYNC;
      x_q       <= '0;
      y_q       <= '0;
      max_x_q   <= '0;
      line_de_q <= 1'b0;
      hs_prev_q <= HS_BLANK;
      bypass_q  <= 1'b0;
      rx_q      <= '0;
      rw_q      <= '0;
      ry_q      <= '0;
      rh_q      <= '0;
      do_q      <= '0;
      ctl_q     <= CTL_RST;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      max_x_q   <= max_x_d;
      line_de_q <= line_de_d;
      hs_prev_q <= hs_prev_d;
      bypass_q  <= bypass_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      ry_q      <= ry_d;
      rh_q      <= rh_d;
      do_q      <= do_d;
      ctl_q     <= ctl_d;
      err_q     <= err_d;
    end
  end

  assign do_o      = do_q;
  assign de_o      = ctl_q.de;
  assign hs_o      = ctl_q.hs;
  assign vs_o      = ctl_q.vs;
  assign roi_err_o = err_q;

endmodule

// File: tb/tb_video_crop.sv
// Randomized-sparsity frame stimulus for video_crop, scoreboarded against a pixel-window model.
module tb_video_crop;

  localparam int PW = 8;
  localparam int XW = 13;
  localparam int YW = 13;
  localparam int FW = 16;
  localparam int FH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bypass = 1'b0;
  logic [XW-1:0] roi_x = '0, roi_w = '0;
  logic [YW-1:0] roi_y = '0, roi_h = '0;
  logic [PW-1:0] di_i = '0;
  logic          de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b0;
  logic [PW-1:0] do_o;
  logic          de_o, hs_o, vs_o, roi_err_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int hs_lines = 0, vs_rises = 0, err_pulses = 0;
  logic hs_mon_prev = 1'b1, vs_mon_prev = 1'b0;
  int sparse = 0;

  video_crop dut (
    .clk(clk), .rst(rst), .bypass(bypass),
    .roi_x(roi_x), .roi_y(roi_y), .roi_w(roi_w), .roi_h(roi_h),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .roi_err_o(roi_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output pixel and tallies envelope events.
  always @(posedge clk) begin
    #1;
    if (de_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %0d, expected none", do_o);
      end else begin
        check("pixel_value", int'(do_o), exp_q.pop_front());
      end
    end
    if (hs_mon_prev === 1'b1 && hs_o === 1'b0) hs_lines++;
    if (vs_mon_prev === 1'b0 && vs_o === 1'b1) vs_rises++;
    if (roi_err_o === 1'b1) err_pulses++;
    hs_mon_prev = hs_o;
    vs_mon_prev = vs_o;
  end

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_do"}, int'(do_o), 0);
    check({tag, "_de"}, int'(de_o), 0);
    check({tag, "_hs"}, int'(hs_o), 1);
    check({tag, "_vs"}, int'(vs_o), 0);
    check({tag, "_err"}, int'(roi_err_o), 0);
  endtask

  // One 16x16 frame. ROI/bypass are taken from the inputs at frame start; optionally
  // the ROI inputs change at chg_line, or rst pulses before rst_line.
  task automatic run_frame(input int chg_line, input int rst_line,
                           input int nx, input int ny, input int nw, input int nh);
    int rx, ry, rw, rh, byp, ex_lines, ex_err, dropped, gaps;
    byp = int'(bypass);
    rx = int'(roi_x) & ~1;
    ry = int'(roi_y) & ~1;
    rw = int'(roi_w) & ~1;
    rh = int'(roi_h) & ~1;
    ex_lines = 0;
    dropped = 0;
    ex_err = (!byp && ((rx + rw > FW) || (ry + rh > FH))) ? 1 : 0;

    vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b0;
    repeat (4) cyc();
    for (int y = 0; y < FH; y++) begin
      if (y == chg_line) begin
        roi_x = XW'(nx); roi_y = YW'(ny); roi_w = XW'(nw); roi_h = YW'(nh);
      end
      if (y == rst_line) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        cyc();
        rst = 1'b0;
        dropped = 1;
        ex_err = 0;
      end
      if (!dropped && (byp != 0 || (y >= ry && y < ry + rh))) ex_lines++;
      hs_i = 1'b0;
      cyc();
      for (int x = 0; x < FW; x++) begin
        gaps = sparse ? $urandom_range(0, 2) : 0;
        for (int g = 0; g < gaps; g++) begin
          de_i = 1'b0; di_i = PW'($urandom);
          cyc();
        end
        de_i = 1'b1; di_i = PW'(x);
        if (!dropped && (byp != 0 || (x >= rx && x < rx + rw && y >= ry && y < ry + rh)))
          exp_q.push_back(x);
        cyc();
      end
      de_i = 1'b0; di_i = PW'($urandom);
      cyc();
      hs_i = 1'b1;
      repeat (35) cyc();
    end
    vs_i = 1'b0;
    repeat (10) cyc();

    check("leftover_pixels", exp_q.size(), 0);
    check("kept_lines", hs_lines, ex_lines);
    check("vs_o_rises", vs_rises, 1);
    check("roi_err_pulses", err_pulses, ex_err);
    exp_q.delete();
    hs_lines = 0;
    vs_rises = 0;
    err_pulses = 0;
  endtask

  task automatic set_roi(input int x, input int y, input int w, input int h);
    roi_x = XW'(x); roi_y = YW'(y); roi_w = XW'(w); roi_h = YW'(h);
  endtask

  initial begin
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) cyc();

    set_roi(4, 2, 8, 4);
    for (int s = 0; s < 2; s++) begin
      sparse = s;
      run_frame(-1, -1, 0, 0, 0, 0);
      run_frame(-1, -1, 0, 0, 0, 0);
    end

    sparse = 1;
    bypass = 1'b1;
    run_frame(-1, -1, 0, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 0);
    bypass = 1'b0;

    set_roi(3, 3, 5, 5);
    run_frame(-1, -1, 0, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 0);

    set_roi(12, 12, 8, 8);
    run_frame(-1, -1, 0, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 0);

    set_roi(4, 2, 8, 4);
    run_frame(3, -1, 0, 0, 16, 16);
    run_frame(-1, -1, 0, 0, 0, 0);
    set_roi(4, 2, 0, 4);
    run_frame(-1, -1, 0, 0, 0, 0);

    set_roi(0, 4, 16, 8);
    run_frame(-1, 7, 0, 0, 0, 0);
    run_frame(-1, -1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
